// File: rtl/uart_rx_param_if.sv
// ---------------------------------------------------------------------------
// uart_rx_param_if
// Delivery bundle between the parametrised UART receiver and its consumer.
// The receiver presents one received word at a time with its status flags
// and holds it until the consumer accepts it with ready.
//
// Signals:
//   data        received word, LSB = first bit on the line
//   valid       data and error flags are valid, held until accepted
//   ready       consumer accepts the word when valid && ready
//   frame_err   a stop bit sampled low in the delivered word
//   parity_err  parity mismatch in the delivered word
//   overrun     one-cycle pulse when a completed frame is dropped
//   busy        receiver is in the middle of a frame
//
// Modports:
//   master  the receiver (drives everything except ready)
//   slave   the consumer (drives ready)
// ---------------------------------------------------------------------------
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output data,
        output valid,
        output frame_err,
        output parity_err,
        output overrun,
        output busy,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  parity_err,
        input  overrun,
        input  busy,
        output ready
    );

endinterface

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised asynchronous serial receiver. The rx pin is synchronised,
// a start bit is qualified at its middle, and every following bit
// (data, optional parity, stop bits) is sampled at mid-bit by a baud
// counter. Each completed frame is offered on a valid/ready bundle with
// framing and parity status; a frame that completes while the previous
// word is still waiting is dropped and flagged with an overrun pulse.
//
// Parameters:
//   CLK_DIV    clock cycles per bit (4..65535)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  stop bits checked (1 or 2)
//
// Ports:
//   clk   system clock
//   rstn  synchronous reset, active low
//   rx    serial input, idle high, asynchronous to clk
//   bus   delivery bundle (master side): data, valid, ready, frame_err,
//         parity_err, overrun, busy
// ---------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLK_DIV   = 1250,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rx,
    uart_rx_param_if.master bus
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam bit HAS_PARITY = (PARITY != 0);
    localparam bit ODD_PARITY = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_COMMIT
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 rx_meta;
    logic                 rx_s;

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_cnt_next;
    logic                 strobe;

    logic [DATA_BITS-1:0] shreg;
    logic                 frame_bad;
    logic                 parity_bad;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_q;
    logic                 parity_q;
    logic                 overrun_q;

    logic                 commit;
    logic                 accept;

    // Two-flop synchroniser; flops reset high so a reset never looks like
    // a start bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Sample strobe at the wrap of the baud counter. Because the counter is
    // restarted at the middle of the start bit, every wrap lands mid-bit.
    assign strobe = (cnt == CNT_LAST);

    // Next-state, baud counter and bit counter logic.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_cnt_next = bit_cnt;

        case (state)
            S_IDLE: begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                if (!rx_s) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                // Re-check the line half a bit in; a high level here was a
                // glitch, not a start bit.
                if (cnt == CNT_HALF) begin
                    cnt_next   = '0;
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (strobe) begin
                    cnt_next = '0;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = HAS_PARITY ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (strobe) begin
                    cnt_next   = '0;
                    state_next = S_STOP;
                end
            end

            S_STOP: begin
                // Leave right after the last stop sample so the next start
                // bit can be caught even with no idle gap between frames.
                if (strobe) begin
                    cnt_next = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = S_COMMIT;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end

            S_COMMIT: begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                state_next   = S_IDLE;
            end

            default: begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                state_next   = S_IDLE;
            end
        endcase
    end

    // State register with baud and bit counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    // Frame datapath: shift register plus per-frame error accumulation.
    // Bits enter at the MSB so the first bit on the line ends at the LSB.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shreg      <= '0;
            frame_bad  <= 1'b0;
            parity_bad <= 1'b0;
        end else begin
            if (state == S_START) begin
                frame_bad  <= 1'b0;
                parity_bad <= 1'b0;
            end
            if (state == S_DATA && strobe) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
            // XOR over data and parity bit must be 1 for odd, 0 for even.
            if (state == S_PARITY && strobe) begin
                parity_bad <= (^shreg) ^ rx_s ^ ODD_PARITY;
            end
            if (state == S_STOP && strobe && !rx_s) begin
                frame_bad <= 1'b1;
            end
        end
    end

    assign commit = (state == S_COMMIT);
    assign accept = valid_q && bus.ready;

    // Output holding register. A commit is taken if the slot is empty or
    // is being emptied in the same cycle; otherwise the new frame is lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            parity_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (commit && (!valid_q || accept)) begin
                data_q   <= shreg;
                frame_q  <= frame_bad;
                parity_q <= parity_bad;
                valid_q  <= 1'b1;
            end else begin
                if (commit) begin
                    overrun_q <= 1'b1;
                end
                if (accept) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.frame_err  = frame_q;
    assign bus.parity_err = parity_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Scoreboard bench for uart_rx_param. Two receivers are instantiated:
//   dut_a  8 data bits, no parity, 1 stop bit
//   dut_b  8 data bits, even parity, 2 stop bits
// both with CLK_DIV = 16. The stimulus pushes the expected word into a
// per-receiver queue; a negedge monitor pops and compares on every
// valid && ready handshake.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int CLK_DIV = 16;
    // rx to rx_s (2) + start detect (1) + half bit + 9 sampled bits + commit
    localparam int LAT_A = 2 + 1 + CLK_DIV / 2 + (8 + 0 + 1) * CLK_DIV + 1;
    // rx low -> rx_s low (2) + enter START (1) + half-bit check
    localparam int GLITCH_LIMIT = 2 + CLK_DIV / 2 + 3;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic clk;
    logic rstn;
    logic rx_a;
    logic rx_b;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc_a = 0;
    int   rise_cyc_a = 0;
    int   high_a = 0;
    int   width_a = 0;
    int   ovr_a = 0;
    int   ovr_b = 0;
    logic prev_valid_a = 1'b0;

    uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_param_if #(.DATA_BITS(8)) bus_b ();

    uart_rx_param #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rstn(rstn), .rx(rx_a), .bus(bus_a)
    );

    uart_rx_param #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rstn(rstn), .rx(rx_b), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scalar comparison with pass/fail accounting.
    task automatic compareValue(input string name, input int unsigned act,
                                input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic expectWord(input int sel, input logic [7:0] d,
                              input logic fe, input logic pe);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.pe   = pe;
        if (sel == 0) exp_a.push_back(e);
        else          exp_b.push_back(e);
    endtask

    // Pops the oldest expected word for a receiver and compares it.
    task automatic checkOutput(input int sel, input logic [7:0] d,
                               input logic fe, input logic pe);
        exp_t  e;
        string tag;
        tag = (sel == 0) ? "a" : "b";
        if ((sel == 0 && exp_a.size() == 0) || (sel == 1 && exp_b.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word_%s: actual=0x%0h expected=none", tag, d);
            return;
        end
        e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
        compareValue({"data_", tag}, d, e.data);
        compareValue({"frame_err_", tag}, fe, e.fe);
        compareValue({"parity_err_", tag}, pe, e.pe);
    endtask

    // Monitor: handshake checks plus valid/overrun bookkeeping.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus_a.valid && !prev_valid_a) rise_cyc_a = cyc;
            if (bus_a.valid) begin
                high_a = high_a + 1;
            end else if (high_a != 0) begin
                width_a = high_a;
                high_a  = 0;
            end
            if (bus_a.overrun) ovr_a++;
            if (bus_b.overrun) ovr_b++;
            if (bus_a.valid && bus_a.ready)
                checkOutput(0, bus_a.data, bus_a.frame_err, bus_a.parity_err);
            if (bus_b.valid && bus_b.ready)
                checkOutput(1, bus_b.data, bus_b.frame_err, bus_b.parity_err);
        end
        prev_valid_a = bus_a.valid;
    end

    // Holds one bit on the chosen line for a full bit period. Entered and
    // left 1 time unit after a rising edge.
    task automatic driveBit(input int sel, input logic b);
        if (sel == 0) rx_a = b;
        else          rx_b = b;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] d,
                                 input bit with_par, input logic p,
                                 input int nstop, input logic [1:0] stops);
        if (sel == 0) start_cyc_a = cyc;
        driveBit(sel, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(sel, d[i]);
        if (with_par) driveBit(sel, p);
        for (int i = 0; i < nstop; i++) driveBit(sel, stops[i]);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  glitch_c0;
        int  fall_cyc;
        bit  saw_busy;

        rstn        = 1'b0;
        rx_a        = 1'b1;
        rx_b        = 1'b1;
        bus_a.ready = 1'b1;
        bus_b.ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        compareValue("rst_valid_a", bus_a.valid, 0);
        compareValue("rst_data_a", bus_a.data, 0);
        compareValue("rst_frame_err_a", bus_a.frame_err, 0);
        compareValue("rst_parity_err_a", bus_a.parity_err, 0);
        compareValue("rst_overrun_a", bus_a.overrun, 0);
        compareValue("rst_busy_a", bus_a.busy, 0);
        compareValue("rst_valid_b", bus_b.valid, 0);
        compareValue("rst_data_b", bus_b.data, 0);
        compareValue("rst_frame_err_b", bus_b.frame_err, 0);
        compareValue("rst_parity_err_b", bus_b.parity_err, 0);
        compareValue("rst_overrun_b", bus_b.overrun, 0);
        compareValue("rst_busy_b", bus_b.busy, 0);
        rstn = 1'b1;
        idleCycles(5);

        // 0x55, 8N1: latency and single-cycle valid pulse.
        $display("[TB] frame 0x55 on 8N1");
        expectWord(0, 8'h55, 1'b0, 1'b0);
        applyStimulus(0, 8'h55, 1'b0, 1'b0, 1, 2'b01);
        compareValue("latency_a", rise_cyc_a - start_cyc_a, LAT_A);
        compareValue("valid_pulse_width_a", width_a, 1);
        idleCycles(20);

        // 0x00 then 0xFF with a low stop bit, back-to-back.
        $display("[TB] frames 0x00 and 0xFF (bad stop) on 8N1");
        expectWord(0, 8'h00, 1'b0, 1'b0);
        applyStimulus(0, 8'h00, 1'b0, 1'b0, 1, 2'b01);
        expectWord(0, 8'hFF, 1'b1, 1'b0);
        applyStimulus(0, 8'hFF, 1'b0, 1'b0, 1, 2'b00);
        rx_a = 1'b1;
        idleCycles(40);

        // Even parity, 2 stop bits. 0xA3 has four ones: p=0 good, p=1 bad.
        $display("[TB] parity and stop-bit frames on 8E2");
        expectWord(1, 8'hA3, 1'b0, 1'b0);
        applyStimulus(1, 8'hA3, 1'b1, 1'b0, 2, 2'b11);
        expectWord(1, 8'hA3, 1'b0, 1'b1);
        applyStimulus(1, 8'hA3, 1'b1, 1'b1, 2, 2'b11);
        expectWord(1, 8'h3C, 1'b1, 1'b0);
        applyStimulus(1, 8'h3C, 1'b1, 1'b0, 2, 2'b10);
        rx_b = 1'b1;
        idleCycles(40);

        // Short low glitch while idle: busy must rise then clear, no word.
        $display("[TB] idle glitch on 8N1");
        glitch_c0 = cyc;
        rx_a = 1'b0;
        idleCycles(CLK_DIV / 4);
        rx_a = 1'b1;
        saw_busy = 1'b0;
        fall_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.busy) saw_busy = 1'b1;
            else if (saw_busy && fall_cyc < 0) fall_cyc = cyc;
        end
        compareValue("glitch_busy_seen", saw_busy, 1);
        checks++;
        if (fall_cyc < 0 || (fall_cyc - glitch_c0) > GLITCH_LIMIT) begin
            errors++;
            $display("[TB] FAIL glitch_busy_release: actual=%0d cycles required<=%0d",
                     fall_cyc - glitch_c0, GLITCH_LIMIT);
        end
        idleCycles(10);

        // Overrun: consumer stalled, 0x11 then 0x22 back-to-back.
        $display("[TB] overrun with ready low");
        ovr_a = 0;
        bus_a.ready = 1'b0;
        expectWord(0, 8'h11, 1'b0, 1'b0);
        applyStimulus(0, 8'h11, 1'b0, 1'b0, 1, 2'b01);
        applyStimulus(0, 8'h22, 1'b0, 1'b0, 1, 2'b01);
        idleCycles(4);
        compareValue("ovr_hold_valid", bus_a.valid, 1);
        compareValue("ovr_hold_data", bus_a.data, 8'h11);
        compareValue("ovr_pulse_count", ovr_a, 1);
        bus_a.ready = 1'b1;
        idleCycles(2);
        compareValue("ovr_valid_fall", bus_a.valid, 0);
        idleCycles(10);

        // Reset in the middle of the data bits, then a clean 0x7E.
        $display("[TB] reset during data bits");
        driveBit(0, 1'b0);
        driveBit(0, 1'b1);
        driveBit(0, 1'b0);
        rx_a = 1'b0;
        idleCycles(CLK_DIV / 2);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        rx_a = 1'b1;
        compareValue("abort_busy_a", bus_a.busy, 0);
        compareValue("abort_valid_a", bus_a.valid, 0);
        compareValue("abort_data_a", bus_a.data, 0);
        idleCycles(40);
        expectWord(0, 8'h7E, 1'b0, 1'b0);
        applyStimulus(0, 8'h7E, 1'b0, 1'b0, 1, 2'b01);
        idleCycles(20);

        // Drain the scoreboards with a bounded wait.
        for (int i = 0; i < 300 && (exp_a.size() != 0 || exp_b.size() != 0); i++)
            @(negedge clk);
        compareValue("drain_a", exp_a.size(), 0);
        compareValue("drain_b", exp_b.size(), 0);
        compareValue("overrun_b", ovr_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
